// File: rtl/sprite_write_arbiter_if.sv
// rtl/sprite_write_arbiter_if.sv - requester and GPU FIFO signal bundle for the sprite write arbiter
interface sprite_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic                    wr_window;
  logic                    frame_start;
  logic                    fifo_full;
  logic                    fifo_wrreq;
  logic [ADDR_W+DATA_W-1:0] fifo_data;
  logic [7:0]              frame_writes;

  modport master (
    output req, req_addr, req_data, wr_window, frame_start, fifo_full,
    input  ack, fifo_wrreq, fifo_data, frame_writes
  );

  modport slave (
    input  req, req_addr, req_data, wr_window, frame_start, fifo_full,
    output ack, fifo_wrreq, fifo_data, frame_writes
  );
endinterface

// File: rtl/sprite_write_arbiter.sv
// rtl/sprite_write_arbiter.sv - round-robin arbiter funnelling sprite register writes into the GPU FIFO
module sprite_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int FD_W  = ADDR_W + DATA_W;

  typedef enum logic {ARB, WRITE} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [FD_W-1:0]  fifo_data_q, fifo_data_d;
  logic [7:0]       frame_writes_q, frame_writes_d;

  logic             found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic             wrreq;
  logic [N_REQ-1:0] ack;

  // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_ptr_q + PTR_W'(k);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    fifo_data_d    = fifo_data_q;
    frame_writes_d = frame_writes_q;
    wrreq          = 1'b0;
    ack            = '0;

    case (state_q)
      ARB: begin
        if (bus.wr_window && found) begin
          grant_d     = win_idx;
          fifo_data_d = {bus.req_addr[win_idx*ADDR_W +: ADDR_W],
                         bus.req_data[win_idx*DATA_W +: DATA_W]};
          state_d     = WRITE;
        end
      end
      WRITE: begin
        // Reset in this cycle abandons the committed write outright.
        if (!bus.fifo_full && !reset) begin
          wrreq        = 1'b1;
          ack[grant_q] = 1'b1;
          rr_ptr_d     = grant_q + PTR_W'(1);
          state_d      = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if (bus.frame_start) begin
      frame_writes_d = wrreq ? 8'd1 : 8'd0;
    end else if (wrreq && frame_writes_q != 8'hFF) begin
      frame_writes_d = frame_writes_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ARB;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      fifo_data_q    <= '0;
      frame_writes_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      fifo_data_q    <= fifo_data_d;
      frame_writes_q <= frame_writes_d;
    end
  end

  assign bus.ack          = ack;
  assign bus.fifo_wrreq   = wrreq;
  assign bus.fifo_data    = fifo_data_q;
  assign bus.frame_writes = frame_writes_q;
endmodule
